// File: rtl/cart_mapper_pkg.sv
// Shared types and constants for the bank-switching cartridge mapper.
// The unlock key sequence lives here so the FSM and the top agree on it.
package cart_mapper_pkg;

   typedef enum logic [1:0] {LOCKED, ARM, UNLOCKED} unlock_state_e;

   localparam logic [7:0] UNLOCK_KEY1 = 8'h55;
   localparam logic [7:0] UNLOCK_KEY2 = 8'hAA;
   localparam logic [7:0] RELOCK_KEY  = 8'h00;
   localparam logic [3:0] UNLOCK_PAGE = 4'h5;
   localparam logic [2:0] WINDOW_BASE = 3'b010;

   localparam int unsigned ADDR_W = 25;

endpackage

// File: rtl/cart_sram_unlock.sv
// SRAM write-protect unlock sequencer: 0x55, 0xAA unlocks, 0x00 relocks.
// With UNLOCK_EN=0 the FSM is not built and SRAM is never protected.
module cart_sram_unlock
   import cart_mapper_pkg::*;
#(
   parameter int unsigned UNLOCK_EN = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_evt,
   input  logic [7:0] din,
   input  logic       hit,
   output logic       sram_wp
);

   if (UNLOCK_EN != 0) begin : g_fsm
      unlock_state_e state_q, state_d;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) state_q <= LOCKED;
         else       state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         if (wr_evt && hit) begin
            unique case (state_q)
               LOCKED:   state_d = (din == UNLOCK_KEY1) ? ARM : LOCKED;
               ARM: begin
                  if (din == UNLOCK_KEY2)      state_d = UNLOCKED;
                  else if (din == UNLOCK_KEY1) state_d = ARM;
                  else                         state_d = LOCKED;
               end
               UNLOCKED: state_d = (din == RELOCK_KEY) ? LOCKED : UNLOCKED;
               default:  state_d = LOCKED;
            endcase
         end
      end

      // reset term makes sram_we drop combinationally during a reset pulse
      always_comb begin
         sram_wp = reset || (state_q != UNLOCKED);
      end
   end else begin : g_open
      assign sram_wp = 1'b0;
   end

endmodule

// File: rtl/cart_sram_mapper.sv
// 8 KB-window bank mapper from 0x4000 with battery SRAM pages, a write-edge
// detector so held writes act once, and an unlock-gated SRAM write enable.
module cart_sram_mapper
   import cart_mapper_pkg::*;
#(
   parameter int unsigned BANKS        = 4,
   parameter int unsigned BANK_BITS    = 6,
   parameter int unsigned SRAM_SEL_BIT = 4,
   parameter int unsigned FIXED_BANK0  = 1,
   parameter int unsigned SRAM_WR_ANY  = 0,
   parameter int unsigned UNLOCK_EN    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       cpu_addr,
   input  logic [7:0]        din,
   input  logic              cpu_mreq,
   input  logic              cpu_wr,
   input  logic              cs,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              sram_cs,
   output logic              sram_we,
   output logic              sram_wp
);

   localparam logic [ADDR_W-1:0] ROM_MASK = ADDR_W'((1 << SRAM_SEL_BIT) - 1);

   logic                 wr_now, wr_prev, wr_evt;
   logic [2:0]           page, win;
   logic                 in_range, unlock_hit, is_sram, wr_win_ok;
   logic [BANK_BITS-1:0] bank [BANKS];
   logic [BANK_BITS-1:0] sel_bank;
   logic [ADDR_W-1:0]    wide, sram_off, rom_off;

   assign wr_now = cs && cpu_mreq && cpu_wr;
   assign wr_evt = wr_now && !wr_prev;

   // wr_prev resets high so a write held across reset release is ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) wr_prev <= 1'b1;
      else       wr_prev <= wr_now;
   end

   assign page       = cpu_addr[15:13];
   assign win        = page - WINDOW_BASE;
   assign in_range   = (page >= WINDOW_BASE) && (32'(win) < BANKS);
   assign unlock_hit = (cpu_addr[15:12] == UNLOCK_PAGE);

   for (genvar i = 0; i < BANKS; i++) begin : g_bank
      if (i == 0 && FIXED_BANK0 != 0) begin : g_fixed
         assign bank[i] = '0;
      end else begin : g_reg
         logic [BANK_BITS-1:0] bank_q;
         logic                 bank_we;

         assign bank_we = wr_evt && in_range && (32'(win) == i) && !cpu_addr[12];

         always_ff @(posedge clk or posedge reset) begin
            if (reset)        bank_q <= BANK_BITS'(i);
            else if (bank_we) bank_q <= din[BANK_BITS-1:0];
         end

         assign bank[i] = bank_q;
      end
   end

   always_comb begin
      sel_bank = '0;
      for (int i = 0; i < BANKS; i++) begin
         if (32'(win) == i) sel_bank = bank[i];
      end
   end

   always_comb begin
      wide     = ADDR_W'(sel_bank);
      is_sram  = in_range && sel_bank[SRAM_SEL_BIT];
      // SRAM page keeps only 4 KB, mirrored across the 8 KB window
      sram_off = ((wide >> (SRAM_SEL_BIT + 1)) << 12) | ADDR_W'(cpu_addr[11:0]);
      rom_off  = ((wide & ROM_MASK) << 13) | ADDR_W'(cpu_addr[12:0]);
      if (!in_range)    mem_addr = '0;
      else if (is_sram) mem_addr = sram_off;
      else              mem_addr = rom_off;
   end

   assign wr_win_ok = (SRAM_WR_ANY != 0) || (32'(win) == BANKS - 1);
   assign sram_cs   = cs && is_sram;
   assign sram_we   = sram_cs && cpu_mreq && cpu_wr && cpu_addr[12] && wr_win_ok &&
                      !unlock_hit && !sram_wp;

   cart_sram_unlock #(
      .UNLOCK_EN (UNLOCK_EN)
   ) u_unlock (
      .clk     (clk),
      .reset   (reset),
      .wr_evt  (wr_evt),
      .din     (din),
      .hit     (unlock_hit),
      .sram_wp (sram_wp)
   );

endmodule

// File: tb/tb_cart_sram_mapper.sv
// Directed bench for cart_sram_mapper: default build plus a 6-window,
// any-window-SRAM-write build driven by the same bus.
module tb_cart_sram_mapper;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  din;
   logic        cpu_mreq, cpu_wr, cs;
   logic [24:0] mem_addr, mem_addr6;
   logic        sram_cs, sram_we, sram_wp;
   logic        sram_cs6, sram_we6, sram_wp6;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cart_sram_mapper dut (
      .clk      (clk),
      .reset    (reset),
      .cpu_addr (cpu_addr),
      .din      (din),
      .cpu_mreq (cpu_mreq),
      .cpu_wr   (cpu_wr),
      .cs       (cs),
      .mem_addr (mem_addr),
      .sram_cs  (sram_cs),
      .sram_we  (sram_we),
      .sram_wp  (sram_wp)
   );

   cart_sram_mapper #(
      .BANKS       (6),
      .SRAM_WR_ANY (1)
   ) dut6 (
      .clk      (clk),
      .reset    (reset),
      .cpu_addr (cpu_addr),
      .din      (din),
      .cpu_mreq (cpu_mreq),
      .cpu_wr   (cpu_wr),
      .cs       (cs),
      .mem_addr (mem_addr6),
      .sram_cs  (sram_cs6),
      .sram_we  (sram_we6),
      .sram_wp  (sram_wp6)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [15:0] a);
      cpu_addr = a; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b0;
      #1;
   endtask

   task automatic start_wr(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; din = d; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
      #1;
   endtask

   task automatic end_wr();
      @(posedge clk); #1;
      cpu_wr = 1'b0; cpu_mreq = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      start_wr(a, d);
      end_wr();
   endtask

   initial begin
      reset = 1'b1; cpu_addr = '0; din = '0; cpu_mreq = 1'b0; cpu_wr = 1'b0; cs = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // reset mapping
      rd(16'h4000); chk("rst_4000", mem_addr, 32'h00000);
      chk("rst_cs", sram_cs, 1'b0);
      chk("rst_wp", sram_wp, 1'b1);
      rd(16'h6000); chk("rst_6000", mem_addr, 32'h02000);
      rd(16'h8000); chk("rst_8000", mem_addr, 32'h04000);
      rd(16'hA000); chk("rst_A000", mem_addr, 32'h06000);

      // SRAM page mapping
      wr(16'hA000, 8'h12);
      rd(16'hB123); chk("sram12_cs", sram_cs, 1'b1);
      chk("sram12_addr", mem_addr, 32'h0123);
      wr(16'hA000, 8'h32);
      rd(16'hB123); chk("sram32_addr", mem_addr, 32'h1123);

      // write protect and unlock
      wr(16'hA000, 8'h10);
      start_wr(16'hB000, 8'hC3); chk("locked_we", sram_we, 1'b0);
      end_wr();
      wr(16'h5000, 8'h55);
      chk("arm_wp", sram_wp, 1'b1);
      wr(16'h5000, 8'hAA);
      chk("unlocked_wp", sram_wp, 1'b0);
      start_wr(16'hB000, 8'hC3); chk("unlocked_we", sram_we, 1'b1);
      chk("unlocked_addr", mem_addr, 32'h0000);
      end_wr();
      start_wr(16'h5000, 8'h00); chk("unlock_page_we", sram_we, 1'b0);
      end_wr();
      chk("relock_wp", sram_wp, 1'b1);

      // broken sequence stays locked
      wr(16'h5000, 8'h55);
      wr(16'h5000, 8'h33);
      wr(16'h5000, 8'hAA);
      chk("broken_seq_wp", sram_wp, 1'b1);

      // held bank write acts once with the first data
      start_wr(16'h6000, 8'h07);
      repeat (2) @(posedge clk);
      #1 din = 8'h01;
      repeat (2) @(posedge clk);
      end_wr();
      rd(16'h6000); chk("held_bank1", mem_addr, 32'h0E000);

      // held unlock write counts once: later data change must not relock
      start_wr(16'h5000, 8'h55);
      repeat (2) @(posedge clk);
      #1 din = 8'h11;
      repeat (2) @(posedge clk);
      end_wr();
      chk("held_arm_wp", sram_wp, 1'b1);
      wr(16'h5000, 8'hAA);
      chk("held_arm_unlock", sram_wp, 1'b0);

      // window 0 is hard-wired
      wr(16'h4000, 8'h09);
      rd(16'h4000); chk("fixed_bank0", mem_addr, 32'h0);

      // non-last SRAM window: only the any-window build may write
      wr(16'h6000, 8'h10);
      start_wr(16'h7000, 8'h5A);
      chk("win1_we_last_only", sram_we, 1'b0);
      chk("win1_we_any", sram_we6, 1'b1);
      end_wr();

      // window 5 on the 6-window build
      wr(16'hE000, 8'h10);
      start_wr(16'hF004, 8'h5A);
      chk("w5_we", sram_we6, 1'b1);
      chk("w5_addr", mem_addr6, 32'h0004);
      chk("w5_oor_addr", mem_addr, 32'h0);
      chk("w5_oor_we", sram_we, 1'b0);
      end_wr();
      rd(16'h3000);
      chk("low_addr", mem_addr6, 32'h0);
      chk("low_cs", sram_cs6, 1'b0);

      // reset mid-access, then a write held across reset release
      start_wr(16'hB000, 8'hC3); chk("pre_reset_we", sram_we, 1'b1);
      reset = 1'b1;
      #1;
      chk("reset_we", sram_we, 1'b0);
      chk("reset_wp", sram_wp, 1'b1);
      cpu_addr = 16'h6000; din = 8'h05;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      end_wr();
      rd(16'h6000); chk("held_over_reset", mem_addr, 32'h02000);
      chk("post_reset_wp", sram_wp, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
